fetch_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 29 ++
 rtl/fetch_stage.sv | 188 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the front-end pipeline.
//
// Contents:
//   XLEN          - architectural register / address width
//   PC_STEP       - sequential PC increment (one 32-bit instruction word)
//   NOP_INSTR     - canonical bubble, addi x0,x0,0
//   fetch_state_t - fetch-stage handshake states
//   align_word()  - clears the byte-offset bits of an address
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // ISSUE : request on the bus, waiting for the grant
    // WAIT  : request granted, waiting for read data
    // HOLD  : read data parked in the hold buffer while decode stalls
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage.
//
// Holds the program counter, fetches one instruction word at a time from
// instruction memory over a req/gnt/rvalid handshake, and presents the
// PC/instruction pair to the IF/ID pipeline register. At most one request
// is outstanding. A response that arrives while decode is stalled is parked
// in a one-entry hold buffer. A redirect reloads the PC and marks any
// in-flight response as stale so it is dropped when it returns.
//
// Ports:
//   clk           in   1   clock, rising edge
//   rst           in   1   synchronous active-high reset
//   MuxControlEn  in   1   decode stall, Instruction not taken this cycle
//   ControlHazard in   1   redirect / flush request
//   BranchTarget  in  32   redirect PC, valid with ControlHazard
//   ImemReq       out  1   fetch request
//   ImemAddr      out 32   fetch word address (bits [1:0] always 0)
//   ImemGnt       in   1   request accepted this cycle
//   ImemRvalid    in   1   read data valid
//   ImemRdata     in  32   instruction word
//   PCDec         out 32   PC of the presented instruction
//   Instruction   out 32   presented instruction
//   FetchValid    out  1   Instruction/PCDec carry a real fetch
module fetch_stage #(
    parameter logic [riscv_pkg::XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [riscv_pkg::XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MuxControlEn,
    input  logic        ControlHazard,
    input  logic [31:0] BranchTarget,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRvalid,
    input  logic [31:0] ImemRdata,
    output logic [31:0] PCDec,
    output logic [31:0] Instruction,
    output logic        FetchValid
);

    import riscv_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            discard_q, discard_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;

    // ------------------------------------------------------------------
    // State register: FSM state plus PC, request tag and hold buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ISSUE;
            pc_q         <= align_word(RESET_PC);
            req_pc_q     <= '0;
            discard_q    <= 1'b0;
            hold_pc_q    <= '0;
            hold_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            discard_q    <= discard_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        discard_d    = discard_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;

        if (ControlHazard) begin
            // Redirect beats every normal transition; the target replaces
            // the PC even when a grant lands in the same cycle.
            pc_d = align_word(BranchTarget);
            unique case (state_q)
                ISSUE: begin
                    if (ImemGnt) begin
                        // The request just granted is for the old path.
                        discard_d = 1'b1;
                        state_d   = WAIT;
                    end
                end
                WAIT: begin
                    if (ImemRvalid) begin
                        discard_d = 1'b0;
                        state_d   = ISSUE;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                HOLD: begin
                    state_d = ISSUE;
                end
                default: begin
                    state_d = ISSUE;
                end
            endcase
        end else begin
            unique case (state_q)
                ISSUE: begin
                    if (ImemGnt) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + PC_STEP;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (ImemRvalid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = ISSUE;
                        end else if (MuxControlEn) begin
                            hold_pc_d    = req_pc_q;
                            hold_instr_d = ImemRdata;
                            state_d      = HOLD;
                        end else begin
                            state_d = ISSUE;
                        end
                    end
                end
                HOLD: begin
                    if (!MuxControlEn) begin
                        state_d = ISSUE;
                    end
                end
                default: begin
                    state_d = ISSUE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        ImemReq     = 1'b0;
        ImemAddr    = pc_q;
        FetchValid  = 1'b0;
        Instruction = NOP_INSTR;
        PCDec       = '0;

        if (!rst) begin
            ImemReq = (state_q == ISSUE);

            // A response that is not stale and not stalled passes straight
            // through to the IF/ID register in the cycle it arrives.
            if (!ControlHazard) begin
                unique case (state_q)
                    WAIT: begin
                        if (ImemRvalid && !discard_q && !MuxControlEn) begin
                            FetchValid  = 1'b1;
                            Instruction = ImemRdata;
                            PCDec       = req_pc_q;
                        end
                    end
                    HOLD: begin
                        FetchValid  = 1'b1;
                        Instruction = hold_instr_q;
                        PCDec       = hold_pc_q;
                    end
                    default: begin
                        FetchValid = 1'b0;
                    end
                endcase
            end
        end
    end

    // Read data may only return while a granted request is outstanding.
    a_rvalid_only_in_wait: assert property (
        @(posedge clk) disable iff (rst) ImemRvalid |-> (state_q == WAIT)
    );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        MuxControlEn;
    logic        ControlHazard;
    logic [31:0] BranchTarget;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemRvalid;
    logic [31:0] ImemRdata;
    logic [31:0] PCDec;
    logic [31:0] Instruction;
    logic        FetchValid;

    int checks = 0;
    int errors = 0;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .MuxControlEn (MuxControlEn),
        .ControlHazard(ControlHazard),
        .BranchTarget (BranchTarget),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemGnt      (ImemGnt),
        .ImemRvalid   (ImemRvalid),
        .ImemRdata    (ImemRdata),
        .PCDec        (PCDec),
        .Instruction  (Instruction),
        .FetchValid   (FetchValid)
    );

    always #5 clk = ~clk;

    // Memory contents used by the random test: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        MuxControlEn  = 1'b0;
        ControlHazard = 1'b0;
        BranchTarget  = 32'h0;
        ImemGnt       = 1'b0;
        ImemRvalid    = 1'b0;
        ImemRdata     = 32'h0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", ImemReq); end
        checks++; if (FetchValid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b expected 0", FetchValid); end
        checks++; if (Instruction !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", Instruction, NOP); end
        checks++; if (PCDec !== 32'h0) begin errors++; $display("FAIL reset_pcdec: got %h expected 0", PCDec); end
        rst = 1'b0;
        #1;
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin errors++; $display("FAIL reset_release: req %b addr %h expected 1/00000000", ImemReq, ImemAddr); end
    endtask

    task automatic test_basic_fetch;
        do_reset();
        ImemGnt = 1'b1;
        #1;
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin errors++; $display("FAIL basic_issue: req %b addr %h expected 1/00000000", ImemReq, ImemAddr); end
        tick();
        ImemGnt = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'h0050_0093;
        #1;
        checks++; if (FetchValid !== 1'b1) begin errors++; $display("FAIL basic_fv: got %b expected 1", FetchValid); end
        checks++; if (Instruction !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr: got %h expected 00500093", Instruction); end
        checks++; if (PCDec !== 32'h0) begin errors++; $display("FAIL basic_pcdec: got %h expected 0", PCDec); end
        tick();
        ImemRvalid = 1'b0;
        #1;
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h4) begin errors++; $display("FAIL basic_next: req %b addr %h expected 1/00000004", ImemReq, ImemAddr); end
    endtask

    task automatic test_gnt_wait;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin errors++; $display("FAIL gntwait_stable[%0d]: req %b addr %h expected 1/00000000", i, ImemReq, ImemAddr); end
            tick();
        end
        ImemGnt = 1'b1;
        tick();
        ImemGnt = 1'b0;
        #1;
        checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL gntwait_wait_req: got %b expected 0", ImemReq); end
        ImemRvalid = 1'b1; ImemRdata = 32'h1234_5678;
        #1;
        checks++; if (FetchValid !== 1'b1 || PCDec !== 32'h0) begin errors++; $display("FAIL gntwait_data: fv %b pc %h expected 1/00000000", FetchValid, PCDec); end
        tick();
        ImemRvalid = 1'b0;
        #1;
        checks++; if (ImemAddr !== 32'h4) begin errors++; $display("FAIL gntwait_advance: got %h expected 00000004", ImemAddr); end
    endtask

    task automatic test_stall_hold;
        do_reset();
        ImemGnt = 1'b1; tick();
        ImemGnt = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'h0050_0093; tick();
        ImemRvalid = 1'b0;
        // Second fetch at 0x4 with decode stalled before the data returns.
        MuxControlEn = 1'b1; ImemGnt = 1'b1; tick();
        ImemGnt = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'h00A0_0113;
        #1;
        checks++; if (FetchValid !== 1'b0 || ImemReq !== 1'b0) begin errors++; $display("FAIL stall_rvalid: fv %b req %b expected 0/0", FetchValid, ImemReq); end
        tick();
        ImemRvalid = 1'b0; ImemRdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (FetchValid !== 1'b1 || Instruction !== 32'h00A0_0113 || PCDec !== 32'h4) begin errors++; $display("FAIL stall_hold[%0d]: fv %b instr %h pc %h expected 1/00a00113/00000004", i, FetchValid, Instruction, PCDec); end
            checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL stall_noreq[%0d]: got %b expected 0", i, ImemReq); end
            tick();
        end
        MuxControlEn = 1'b0;
        #1;
        checks++; if (FetchValid !== 1'b1 || PCDec !== 32'h4) begin errors++; $display("FAIL stall_release: fv %b pc %h expected 1/00000004", FetchValid, PCDec); end
        tick();
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h8) begin errors++; $display("FAIL stall_next: req %b addr %h expected 1/00000008", ImemReq, ImemAddr); end
    endtask

    task automatic test_redirect_wait;
        do_reset();
        ImemGnt = 1'b1; tick();
        ImemGnt = 1'b0; ControlHazard = 1'b1; BranchTarget = 32'h100;
        #1;
        checks++; if (FetchValid !== 1'b0 || ImemReq !== 1'b0) begin errors++; $display("FAIL rdw_hazard: fv %b req %b expected 0/0", FetchValid, ImemReq); end
        tick();
        ControlHazard = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (FetchValid !== 1'b0) begin errors++; $display("FAIL rdw_stale: got %b expected 0", FetchValid); end
        tick();
        ImemRvalid = 1'b0;
        #1;
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h100) begin errors++; $display("FAIL rdw_addr: req %b addr %h expected 1/00000100", ImemReq, ImemAddr); end
        ImemGnt = 1'b1; tick();
        ImemGnt = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'h0011_0113;
        #1;
        checks++; if (FetchValid !== 1'b1 || PCDec !== 32'h100 || Instruction !== 32'h0011_0113) begin errors++; $display("FAIL rdw_first: fv %b pc %h instr %h expected 1/00000100/00110113", FetchValid, PCDec, Instruction); end
        tick();
        ImemRvalid = 1'b0;
    endtask

    task automatic test_redirect_gnt;
        do_reset();
        ImemGnt = 1'b1; ControlHazard = 1'b1; BranchTarget = 32'h203;
        #1;
        checks++; if (FetchValid !== 1'b0) begin errors++; $display("FAIL rdg_fv: got %b expected 0", FetchValid); end
        tick();
        ImemGnt = 1'b0; ControlHazard = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'hCAFE_F00D;
        #1;
        checks++; if (FetchValid !== 1'b0 || ImemReq !== 1'b0) begin errors++; $display("FAIL rdg_discard: fv %b req %b expected 0/0", FetchValid, ImemReq); end
        tick();
        ImemRvalid = 1'b0;
        #1;
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h200) begin errors++; $display("FAIL rdg_addr: req %b addr %h expected 1/00000200", ImemReq, ImemAddr); end
    endtask

    task automatic test_reset_in_hold;
        do_reset();
        MuxControlEn = 1'b1;
        ImemGnt = 1'b1; tick();
        ImemGnt = 1'b0; ImemRvalid = 1'b1; ImemRdata = 32'h0070_0193; tick();
        ImemRvalid = 1'b0;
        #1;
        checks++; if (FetchValid !== 1'b1 || PCDec !== 32'h0) begin errors++; $display("FAIL rsthold_pre: fv %b pc %h expected 1/00000000", FetchValid, PCDec); end
        rst = 1'b1;
        #1;
        checks++; if (FetchValid !== 1'b0 || Instruction !== NOP || PCDec !== 32'h0 || ImemReq !== 1'b0) begin errors++; $display("FAIL rsthold_during: fv %b instr %h pc %h req %b expected 0/00000013/0/0", FetchValid, Instruction, PCDec, ImemReq); end
        tick();
        rst = 1'b0; MuxControlEn = 1'b0;
        #1;
        checks++; if (FetchValid !== 1'b0 || Instruction !== NOP || PCDec !== 32'h0) begin errors++; $display("FAIL rsthold_after: fv %b instr %h pc %h expected 0/00000013/0", FetchValid, Instruction, PCDec); end
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin errors++; $display("FAIL rsthold_addr: req %b addr %h expected 1/00000000", ImemReq, ImemAddr); end
    endtask

    // Random traffic against a program-order model: every instruction taken
    // by decode must be the next sequential word after the last one taken,
    // or the redirect target if a redirect happened since.
    task automatic test_random;
        logic [31:0] exp_pc;
        logic        busy;
        logic [31:0] busy_addr;
        int          lat;
        int          consumed;
        logic        prev_req, prev_gnt, prev_hz;
        logic [31:0] prev_addr;

        do_reset();
        exp_pc = 32'h0; busy = 1'b0; busy_addr = 32'h0; lat = 0; consumed = 0;
        prev_req = 1'b0; prev_gnt = 1'b0; prev_hz = 1'b0; prev_addr = 32'h0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            MuxControlEn  = ($urandom_range(0, 3) == 0);
            ControlHazard = ($urandom_range(0, 19) == 0);
            BranchTarget  = $urandom;
            ImemGnt       = 1'b0;
            ImemRvalid    = 1'b0;
            if (!busy && ImemReq)
                ImemGnt = ($urandom_range(0, 1) == 1);
            if (busy) begin
                if (lat == 0) ImemRvalid = ($urandom_range(0, 1) == 1);
                else lat--;
            end
            ImemRdata = ImemRvalid ? mem_word(busy_addr) : $urandom;
            #1;

            checks++; if (ImemAddr[1:0] !== 2'b00) begin errors++; $display("FAIL rnd_align: cycle %0d addr %h", cyc, ImemAddr); end
            if (prev_req && !prev_gnt && !prev_hz) begin
                checks++; if (ImemReq !== 1'b1 || ImemAddr !== prev_addr) begin errors++; $display("FAIL rnd_stable: cycle %0d req %b addr %h expected 1/%h", cyc, ImemReq, ImemAddr, prev_addr); end
            end
            if (ControlHazard) begin
                checks++; if (FetchValid !== 1'b0) begin errors++; $display("FAIL rnd_hazard_fv: cycle %0d got %b expected 0", cyc, FetchValid); end
            end
            if (!FetchValid) begin
                checks++; if (Instruction !== NOP || PCDec !== 32'h0) begin errors++; $display("FAIL rnd_bubble: cycle %0d instr %h pc %h expected 00000013/0", cyc, Instruction, PCDec); end
            end else if (!MuxControlEn) begin
                checks++; if (PCDec !== exp_pc || Instruction !== mem_word(exp_pc)) begin errors++; $display("FAIL rnd_stream: cycle %0d pc %h instr %h expected %h/%h", cyc, PCDec, Instruction, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (ControlHazard)
                exp_pc = {BranchTarget[31:2], 2'b00};

            if (ImemGnt) begin
                busy = 1'b1; busy_addr = ImemAddr; lat = $urandom_range(0, 2);
            end
            if (ImemRvalid) busy = 1'b0;
            prev_req = ImemReq; prev_gnt = ImemGnt; prev_hz = ControlHazard; prev_addr = ImemAddr;
            tick();
        end
        idle_inputs();
        checks++; if (consumed < 50) begin errors++; $display("FAIL rnd_progress: consumed %0d expected at least 50", consumed); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_fetch();
        test_gnt_wait();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_gnt();
        test_reset_in_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
